mix_columns_seq: RTL
====================

// Module: mix_columns_seq
// PURPOSE
// - Column-serial AES MixColumns stage. Sits directly downstream of the ShiftRows stage and consumes its 128-bit state.
// - Applies MixColumns (or InvMixColumns) over GF(2^8), COLS_PER_CYCLE columns per clock.
// - Exchanges data with neighbouring stages through a valid/ready handshake.
// - The final AES round omits MixColumns, so in_last=1 selects a bypass path.
// PARAMETERS
// - COLS_PER_CYCLE  1  columns processed per clock. Legal values: 1, 2, 4. Latency is NCYC = 4/COLS_PER_CYCLE.
// - INVERSE         0  0: MixColumns, matrix {02 03 01 01} circulant. 1: InvMixColumns, matrix {0e 0b 0d 09} circulant.
// PORTS
// - clk        in   1    rising-edge clock
// - rst        in   1    synchronous reset, active high
// - in_state   in   128  state from ShiftRows. Column c = in_state[127-32c -: 32]; row 0 is the MSB byte of each column.
// - in_last    in   1    final-round flag: bypass, out_state = in_state
// - in_valid   in   1    in_state/in_last are valid
// - in_ready   out  1    block can accept; high only in IDLE
// - out_state  out  128  result; same byte layout as in_state
// - out_valid  out  1    out_state is valid; held until out_ready
// - out_ready  in   1    downstream accepts out_state
// BEHAVIOUR
// - Reset (rst=1 at a rising edge):
//   - state goes to IDLE; column counter = 0.
//   - out_valid=0, out_state=128'h0, in_ready=1 from the next cycle.
//   - Reset aborts any block in flight. The partial result is discarded and never presented.
// - FSM states: IDLE, BUSY, DONE.
// - IDLE:
//   - in_ready=1, out_valid=0.
//   - On in_valid=1, latch in_state and in_last into the work register and clear the counter.
//   - in_last=1 -> next state DONE, out_state = in_state unchanged. Latency is 1 cycle.
//   - in_last=0 -> next state BUSY.
// - BUSY:
//   - in_ready=0.
//   - Each cycle, replace COLS_PER_CYCLE columns of the work register, in ascending index order, with their transformed values.
//   - The counter advances by COLS_PER_CYCLE. After the column-3 update, the next state is DONE.
//   - out_valid rises exactly NCYC+1 cycles after the accepting edge. Total latency: 5 cycles at CPC=1, 3 at CPC=2, 2 at CPC=4.
// - DONE:
//   - out_valid=1; out_state = work register, stable.
//   - in_ready=0, so a new input is not accepted in the same cycle.
//   - On out_ready=1, next state is IDLE and out_valid drops.
//   - On out_ready=0, the block holds indefinitely; out_state must not change.
// - Throughput: one block per NCYC+2 cycles at best. There is no overlap of input and output.
// - GF arithmetic:
//   - xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00).
//   - 09/0b/0d/0e are built from repeated xtime plus XOR. All paths are 8 bits wide; there are no carries.
// - Output row r of a column: out_r = m0*a_r ^ m1*a_(r+1 mod 4) ^ m2*a_(r+2 mod 4) ^ m3*a_(r+3 mod 4).
//   - (m0..m3) = {02,03,01,01} forward, {0e,0b,0d,09} inverse.
// - in_valid while in_ready=0 is ignored. The upstream stage must hold in_valid and in_state until it sees in_ready=1.
// - out_ready while out_valid=0 is ignored.
// - in_last is sampled only at acceptance.
// - Illegal COLS_PER_CYCLE values are a configuration error: elaboration fails via a generate-time $error.
// TESTING
// - FIPS-197 forward vector, CPC=1, in_last=0:
//   - Input db135345f20a225c01010101c6c6c6c6 -> out_state 8e4da1bc9fdc589d01010101c6c6c6c6.
//   - out_valid rises 5 cycles after acceptance.
// - Inverse vector, INVERSE=1:
//   - Input 8e4da1bc9fdc589d01010101c6c6c6c6 -> db135345f20a225c01010101c6c6c6c6.
//   - Repeat at CPC=4; out_valid rises 2 cycles after acceptance.
// - Bypass: in_last=1 with input aabbccddeeff00112233445566778899.
//   - Same value is output, out_valid rises 1 cycle after acceptance.
// - Backpressure: hold out_ready=0 for 10 cycles in DONE.
//   - out_state/out_valid stay stable and in_ready stays 0.
//   - Pulsing in_valid with new data during this time is ignored.
// - Reset mid-BUSY: assert rst at the 2nd BUSY cycle.
//   - Next cycle shows out_valid=0, out_state=0, in_ready=1.
//   - A following block d4d4d4d5... (column d4d4d4d5) produces column d5d5d7d6.
// - Back-to-back: random 200 blocks with random in_valid/out_ready stalls, both INVERSE values.
//   - Compare against a behavioural model.
//   - Check that no block is dropped or duplicated.

Source files
------------

// File: rtl/mix_columns_seq.sv
// Column-serial AES (Inv)MixColumns with a valid/ready handshake and final-round bypass.
// A block is accepted in IDLE, transformed in place over 4/COLS_PER_CYCLE BUSY cycles, then held in DONE.

module mix_col_lane #(
  parameter bit INVERSE = 1'b0
) (
  input  logic [31:0] col,
  output logic [31:0] res
);
  localparam logic [3:0] M0 = INVERSE ? 4'he : 4'h2;
  localparam logic [3:0] M1 = INVERSE ? 4'hb : 4'h3;
  localparam logic [3:0] M2 = INVERSE ? 4'hd : 4'h1;
  localparam logic [3:0] M3 = INVERSE ? 4'h9 : 4'h1;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Constant coefficients collapse this case to a fixed XOR network.
  function automatic logic [7:0] mulc(input logic [3:0] m, input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    case (m)
      4'h1:    return b;
      4'h2:    return x2;
      4'h3:    return x2 ^ b;
      4'h9:    return x8 ^ b;
      4'hb:    return x8 ^ x2 ^ b;
      4'hd:    return x8 ^ x4 ^ b;
      4'he:    return x8 ^ x4 ^ x2;
      default: return 8'h00;
    endcase
  endfunction

  logic [7:0] a [4];

  for (genvar j = 0; j < 4; j++) begin : g_byte
    assign a[j] = col[31-8*j -: 8];
  end

  for (genvar r = 0; r < 4; r++) begin : g_row
    assign res[31-8*r -: 8] = mulc(M0, a[r]) ^ mulc(M1, a[(r+1)%4]) ^
                              mulc(M2, a[(r+2)%4]) ^ mulc(M3, a[(r+3)%4]);
  end
endmodule

module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit INVERSE        = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] in_state,
  input  logic         in_last,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_state,
  output logic         out_valid,
  input  logic         out_ready
);
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nx;
  // Column 0 sits at the MSB end, so an ascending packed range maps work[c] to column c.
  logic [0:3][31:0] work;
  logic [2:0]       cnt;
  logic [COLS_PER_CYCLE-1:0][31:0] sel_col, mixed;

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
    assign sel_col[k] = work[cnt[1:0] + 2'(k)];
    mix_col_lane #(.INVERSE(INVERSE)) u_lane (.col(sel_col[k]), .res(mixed[k]));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = in_last ? DONE : BUSY;
      BUSY: if (cnt + 3'(COLS_PER_CYCLE) == 3'd4) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    // Only a finished block is ever visible; partial work stays hidden.
    out_state = (state == DONE) ? work : 128'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          work <= in_state;
          cnt  <= '0;
        end
        BUSY: begin
          for (int k = 0; k < COLS_PER_CYCLE; k++) work[cnt[1:0] + 2'(k)] <= mixed[k];
          cnt <= cnt + 3'(COLS_PER_CYCLE);
        end
        default: ;
      endcase
    end
  end
endmodule
